// File: rtl/fft8_pkg.sv
// Shared constants and helpers for the 8-point radix-2 DIT FFT.
// Twiddles are Q1.8: 256 is unity, 181 approximates cos(pi/4).
package fft8_pkg;

  localparam int N       = 8;
  localparam int LOG2N   = 3;
  localparam int GUARD   = 4;
  localparam int TW_FRAC = 8;
  localparam int TW_ONE  = 256;
  localparam int TW_R2   = 181;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = idx[LOG2N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Combinational complex butterfly A +/- W8^k * B with Q1.8 twiddles.
// Operands are forced to zero when idle so the adders and multipliers stay quiet.
module fft8_butterfly
  import fft8_pkg::*;
#(
  parameter int W = 13
) (
  input  logic                en,
  input  logic [1:0]          k,
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y0_r,
  output logic signed [W-1:0] y0_i,
  output logic signed [W-1:0] y1_r,
  output logic signed [W-1:0] y1_i
);

  localparam int W1 = W + 1;
  localparam int PW = W + TW_FRAC + 2;

  logic signed [W-1:0]  ar, ai, br, bi, mb_r, mb_i, wb_r, wb_i;
  logic signed [W1-1:0] b_sum, b_dif;
  logic signed [PW-1:0] p_sum, p_dif;

  // Round to nearest after the Q1.8 shift, ties away from zero.
  function automatic logic signed [W-1:0] round_q(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] mag;
    mag = p[PW-1] ? -p : p;
    mag = (mag + PW'(TW_ONE / 2)) >>> TW_FRAC;
    return p[PW-1] ? -mag[W-1:0] : mag[W-1:0];
  endfunction

  always_comb begin
    ar   = en ? a_r : '0;
    ai   = en ? a_i : '0;
    br   = en ? b_r : '0;
    bi   = en ? b_i : '0;
    mb_r = (en && k[0]) ? b_r : '0;
    mb_i = (en && k[0]) ? b_i : '0;
    b_sum = W1'(mb_r) + W1'(mb_i);
    b_dif = W1'(mb_i) - W1'(mb_r);
    p_sum = PW'(b_sum) * PW'(TW_R2);
    p_dif = PW'(b_dif) * PW'(TW_R2);
    // Odd k share one constant multiply each on (br+bi) and (bi-br).
    case (k)
      2'd0: begin
        wb_r = br;
        wb_i = bi;
      end
      2'd1: begin
        wb_r = round_q(p_sum);
        wb_i = round_q(p_dif);
      end
      2'd2: begin
        wb_r = bi;
        wb_i = -br;
      end
      default: begin
        wb_r = round_q(p_dif);
        wb_i = -round_q(p_sum);
      end
    endcase
    y0_r = ar + wb_r;
    y0_i = ai + wb_i;
    y1_r = ar - wb_r;
    y1_i = ai - wb_i;
  end

endmodule

// File: rtl/low_power_fft_8.sv
// Serial-in/serial-out 8-point FFT sharing one butterfly across all 12 butterflies.
// Frames load independently of the engine; one start can be held pending.
module low_power_fft_8
  import fft8_pkg::*;
#(
  parameter int width = 9
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    vld_in,
  input  logic signed [width-1:0] in,
  output logic signed [width-1:0] out_r,
  output logic signed [width-1:0] out_i,
  output logic                    vld_out
);

  localparam int MW = width + GUARD;
  localparam logic signed [MW-1:0] SAT_HI = MW'((2 ** (width - 1)) - 1);
  localparam logic signed [MW-1:0] SAT_LO = MW'(-(2 ** (width - 1)));

  logic signed [width-1:0] x_q [N], x_d [N];
  logic signed [MW-1:0]    mr_q [N], mr_d [N], mi_q [N], mi_d [N];
  logic [LOG2N-1:0]        ptr_q, ptr_d;
  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic                    vld_q, vld_d;
  logic signed [width-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic                    load, bf_en, mem_en;
  logic [1:0]              bf_k;
  logic [LOG2N-1:0]        top_idx, bot_idx;
  logic signed [MW-1:0]    y0_r, y0_i, y1_r, y1_i;

  function automatic logic signed [width-1:0] sat(input logic signed [MW-1:0] v);
    if (v > SAT_HI) return SAT_HI[width-1:0];
    if (v < SAT_LO) return SAT_LO[width-1:0];
    return v[width-1:0];
  endfunction

  always_comb begin
    x_d   = x_q;
    ptr_d = ptr_q;
    if (vld_in) begin
      x_d[ptr_q] = in;
      ptr_d      = ptr_q + LOG2N'(1);
    end
    if (start) ptr_d = '0;
  end

  // cnt_q[3:2] is the stage, cnt_q[1:0] the butterfly within it.
  always_comb begin
    bf_k    = '0;
    top_idx = '0;
    bot_idx = '0;
    case (cnt_q[3:2])
      2'd0: begin
        top_idx = {cnt_q[1:0], 1'b0};
        bot_idx = {cnt_q[1:0], 1'b1};
      end
      2'd1: begin
        top_idx = {cnt_q[1], 1'b0, cnt_q[0]};
        bot_idx = {cnt_q[1], 1'b1, cnt_q[0]};
        bf_k    = {cnt_q[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, cnt_q[1:0]};
        bot_idx = {1'b1, cnt_q[1:0]};
        bf_k    = cnt_q[1:0];
      end
    endcase
  end

  fft8_butterfly #(.W(MW)) u_bfly (
    .en   (bf_en),
    .k    (bf_k),
    .a_r  (mr_q[top_idx]),
    .a_i  (mi_q[top_idx]),
    .b_r  (mr_q[bot_idx]),
    .b_i  (mi_q[bot_idx]),
    .y0_r (y0_r),
    .y0_i (y0_i),
    .y1_r (y1_r),
    .y1_i (y1_i)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    out_r_d = '0;
    out_i_d = '0;
    load    = 1'b0;
    bf_en   = 1'b0;
    mr_d    = mr_q;
    mi_d    = mi_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_COMPUTE;
          cnt_d   = '0;
        end
      end
      ST_COMPUTE: begin
        bf_en         = 1'b1;
        mr_d[top_idx] = y0_r;
        mi_d[top_idx] = y0_i;
        mr_d[bot_idx] = y1_r;
        mi_d[bot_idx] = y1_i;
        if (start) pend_d = 1'b1;
        if (cnt_q == 4'd11) begin
          state_d = ST_OUTPUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUTPUT: begin
        vld_d   = 1'b1;
        out_r_d = sat(mr_q[cnt_q[2:0]]);
        out_i_d = sat(mi_q[cnt_q[2:0]]);
        if (cnt_q == 4'd7) begin
          cnt_d = '0;
          if (pend_q || start) begin
            load    = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_COMPUTE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (start) pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Copy from x_d so a sample arriving alongside start is included.
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mr_d[i] = MW'(x_d[bit_rev(LOG2N'(i))]);
        mi_d[i] = '0;
      end
    end
    mem_en = load | bf_en;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
    end
  end

  // Data storage is never reset and only clocks when it has something to hold.
  always_ff @(posedge clk) begin
    if (vld_in) x_q <= x_d;
    if (mem_en) begin
      mr_q <= mr_d;
      mi_q <= mi_d;
    end
  end

  assign out_r   = out_r_q;
  assign out_i   = out_i_q;
  assign vld_out = vld_q;

endmodule

// File: tb/tb_low_power_fft_8.sv
// Directed-plus-random bench for low_power_fft_8 against an arithmetic FFT model.
module tb_low_power_fft_8;

  localparam int WIDTH = 9;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  logic                    clk = 1'b0;
  logic                    rstn, start, vld_in, vld_out;
  logic signed [WIDTH-1:0] din, out_r, out_i;

  int nAssert = 0;
  int nFail   = 0;
  int bufM [8];
  int ptrM = 0;
  int expR [8], expI [8], savR [8], savI [8];
  int cosQ [4] = '{256, 181, 0, -181};
  int sinQ [4] = '{0, 181, 256, 181};

  low_power_fft_8 #(.width(WIDTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .vld_in  (vld_in),
    .in      (din),
    .out_r   (out_r),
    .out_i   (out_i),
    .vld_out (vld_out)
  );

  always #5 clk = ~clk;

  function automatic int roundQ(input int p);
    if (p >= 0) return (p + 128) / 256;
    return -((-p + 128) / 256);
  endfunction

  function automatic int satW(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Textbook in-place DIT FFT over the model buffer, with Q1.8 twiddle rounding.
  function automatic void computeModel();
    int re [8], im [8];
    int half, k, a, b, tr, ti;
    for (int i = 0; i < 8; i++) begin
      re[i] = bufM[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)];
      im[i] = 0;
    end
    for (int m = 2; m <= 8; m = m * 2) begin
      half = m / 2;
      for (int g = 0; g < 8; g += m) begin
        for (int j = 0; j < half; j++) begin
          k  = j * (8 / m);
          a  = g + j;
          b  = a + half;
          tr = roundQ(cosQ[k] * re[b] + sinQ[k] * im[b]);
          ti = roundQ(cosQ[k] * im[b] - sinQ[k] * re[b]);
          re[b] = re[a] - tr;
          im[b] = im[a] - ti;
          re[a] = re[a] + tr;
          im[a] = im[a] + ti;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      expR[i] = satW(re[i]);
      expI[i] = satW(im[i]);
    end
  endfunction

  function automatic void setConst(input int r0);
    for (int i = 0; i < 8; i++) begin
      expR[i] = 0;
      expI[i] = 0;
    end
    expR[0] = r0;
  endfunction

  function automatic int randSample();
    return int'($urandom_range(511)) - 256;
  endfunction

  task automatic check(input string tag, input integer observed, input integer expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int v, input bit withStart);
    din    = WIDTH'(v);
    vld_in = 1'b1;
    start  = withStart;
    bufM[ptrM] = v;
    ptrM = (ptrM + 1) % 8;
    if (withStart) ptrM = 0;
    @(negedge clk);
    vld_in = 1'b0;
    start  = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    ptrM  = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input int expGap, input int nBins);
    int gap;
    gap = 0;
    @(negedge clk);
    while (vld_out !== 1'b1 && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    if (expGap >= 0) check("vld_gap", gap, expGap);
    else check("vld_timeout", (gap < 40) ? 1 : 0, 1);
    for (int b = 0; b < nBins; b++) begin
      check($sformatf("vld_bin%0d", b), vld_out, 1);
      check($sformatf("re_bin%0d", b), out_r, expR[b]);
      check($sformatf("im_bin%0d", b), out_i, expI[b]);
      if (b < nBins - 1) @(negedge clk);
    end
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    check({tag, "_vld"}, vld_out, 0);
    check({tag, "_re"}, out_r, 0);
    check({tag, "_im"}, out_i, 0);
  endtask

  task automatic watchQuiet(input string tag, input int cycles);
    int highs;
    highs = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (vld_out !== 1'b0) highs++;
    end
    check(tag, highs, 0);
  endtask

  initial begin
    rstn   = 1'b1;
    start  = 1'b0;
    vld_in = 1'b0;
    din    = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_vld", vld_out, 0);
    check("rst_re", out_r, 0);
    check("rst_im", out_i, 0);
    rstn = 1'b0;

    $display("[TB] DC frame");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b0);
    watchQuiet("idle_quiet", 4);
    pulseStart();
    setConst(8);
    checkOutput(12, 8);
    checkIdle("dc_end");

    $display("[TB] powers of two");
    for (int i = 0; i < 8; i++) applyStimulus(1 << i, 1'b0);
    pulseStart();
    computeModel();
    checkOutput(12, 8);
    checkIdle("pow2_end");

    $display("[TB] saturation");
    for (int i = 0; i < 8; i++) applyStimulus(255, 1'b0);
    pulseStart();
    setConst(255);
    checkOutput(12, 8);
    for (int i = 0; i < 8; i++) applyStimulus(-256, 1'b0);
    pulseStart();
    setConst(-256);
    checkOutput(12, 8);
    checkIdle("sat_end");

    $display("[TB] random frames, start with last sample");
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 7; i++) applyStimulus(randSample(), 1'b0);
      applyStimulus(randSample(), 1'b1);
      computeModel();
      checkOutput(12, 8);
      checkIdle("rand_end");
    end

    $display("[TB] partial load");
    for (int i = 0; i < 3; i++) applyStimulus(randSample(), 1'b0);
    pulseStart();
    computeModel();
    checkOutput(12, 8);
    checkIdle("partial_end");

    $display("[TB] back-to-back with pending start");
    for (int i = 0; i < 8; i++) applyStimulus(randSample(), 1'b0);
    pulseStart();
    computeModel();
    savR = expR;
    savI = expI;
    for (int i = 0; i < 8; i++) applyStimulus(randSample(), 1'b0);
    pulseStart();
    pulseStart();
    computeModel();
    begin
      int bR [8], bI [8];
      bR = expR;
      bI = expI;
      expR = savR;
      expI = savI;
      checkOutput(-1, 8);
      expR = bR;
      expI = bI;
    end
    checkOutput(12, 8);
    checkIdle("b2b_end");
    watchQuiet("b2b_absorbed", 20);

    $display("[TB] reset during output");
    for (int i = 0; i < 8; i++) applyStimulus(randSample(), 1'b0);
    pulseStart();
    computeModel();
    checkOutput(12, 4);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_vld", vld_out, 0);
    check("midrst_re", out_r, 0);
    check("midrst_im", out_i, 0);
    rstn = 1'b0;
    ptrM = 0;
    watchQuiet("midrst_quiet", 20);

    $display("[TB] recovery frame");
    for (int i = 0; i < 8; i++) applyStimulus(randSample(), 1'b0);
    pulseStart();
    computeModel();
    checkOutput(12, 8);
    checkIdle("recover_end");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/low_power_fft_8.md
# low_power_fft_8

Serial-in/serial-out 8-point radix-2 decimation-in-time FFT for real signed samples. A single shared butterfly unit is time-multiplexed across all 12 butterflies to minimise area and switching activity. Samples are streamed into an input buffer, a `start` pulse launches the transform, and the 8 complex bins stream out in natural order. It sits between a sample front-end and any spectral post-processing logic.

## Interface
- `width`, default 9: bit width of input samples and of each output component (signed two's complement).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-high (asserted = 1), despite the name.
- `start`  in  1  single-cycle pulse; launches a transform of the current input buffer.
- `vld_in`  in  1  qualifies `in`; one sample is captured per cycle while high.
- `in`  in  `width`  real input sample, signed.
- `out_r`  out  `width`  real part of the current output bin, signed.
- `out_i`  out  `width`  imaginary part of the current output bin, signed.
- `vld_out`  out  1  high for exactly 8 consecutive cycles per transform, one per bin.

## Operation
- Input buffer: 8 × `width`. A write pointer (0..7) stores `in` at `x[ptr]` on each cycle with `vld_in`=1, then increments and wraps 7→0. The pointer clears to 0 when `start` is accepted.
- Loading is independent of the engine. A new frame may be written while the previous frame is computing or outputting.
- On accepted `start`, the input buffer is copied in bit-reversed order (0,4,2,6,1,5,3,7) into a working memory of 8 complex words. The words are sign-extended to `width`+4 bits, with the imaginary part set to 0.
- States:
  - IDLE: waiting for `start`.
  - COMPUTE: 12 cycles, covering 3 stages × 4 butterflies with one butterfly per cycle, computed in place.
  - OUTPUT: 8 cycles emitting X[0]..X[7].
  - After OUTPUT the FSM returns to IDLE, or goes directly to COMPUTE if a start is pending.
- `start` while COMPUTE or OUTPUT sets a one-deep pending flag. The buffer copy happens when the pending start is serviced. A second pending start is absorbed, not queued.
- Butterfly: A' = A + W·B and B' = A − W·B.
  - W = W8^k = exp(−j2πk/8), k ∈ {0,1,2,3}.
  - Twiddle constants are Q1.8: cos/sin values are 256, 181, 0, −181, −256.
  - W products are rounded to nearest, with half rounding away from zero, after the >>8.
  - k=0 and k=2 are handled without multipliers (identity and swap/negate).
- Outputs are unscaled. Each component saturates to the signed `width` range [−2^(width−1), 2^(width−1)−1].
- Low power requirements:
  - Working memory and butterfly operand registers are enabled only in COMPUTE.
  - The input buffer is written only on `vld_in`.
  - `out_r`/`out_i` are registered, are zero whenever `vld_out`=0, and toggle only in OUTPUT.

## Timing
- Reset (`rstn`=1 at an edge): FSM→IDLE, pointer=0, pending=0, `vld_out`=0, `out_r`=0, `out_i`=0. Buffers are not cleared.
- Reset mid-COMPUTE or mid-OUTPUT aborts the frame immediately, and the next cycle shows `vld_out`=0.
- `start` sampled at edge T (in IDLE): the copy happens at T, COMPUTE runs over edges T+1..T+12, and `vld_out`=1 with X[0] from edge T+13 through X[7] at T+20.
- Pending start: COMPUTE begins on the edge after X[7] is emitted. There is no gap cycle between frames beyond the 12 COMPUTE cycles.
- `vld_in` and `start` in the same cycle: the sample is written first, then the copy is taken, so the copy includes that sample.
- `start` with fewer than 8 new samples: the transform uses the buffer contents as they stand.

## Structure
- Shared package `fft8_pkg`:
  - N=8 and LOG2N=3.
  - Q1.8 twiddle ROM constants.
  - Guard-bit constant 4.
  - FSM state enum.
  - Bit-reverse function.
- One sub-module, `fft8_butterfly`: combinational complex butterfly with twiddle index input, rounding, and operand isolation.
- The top level contains the input buffer, working memory, the address generator (stage/butterfly counters, k index), the FSM, and the saturating output register.

## Test plan
- Reset: assert `rstn` for 1 cycle → `vld_out`=0 and `out_r`=`out_i`=0 on the following cycle, and no activity until `start`.
- DC: load eight 1s, then `start` → X[0]=(8,0) and X[1..7]=(0,0). `vld_out` runs 8 cycles starting 13 cycles after `start`.
- Powers of two: load 1,2,4,…,128 → X[0]=(255,0), X[4]=(−85,0), X[2]=(−51,102), X[6]=(−51,−102). X[1]/X[7] are conjugates of each other.
- Back-to-back: load frame A, `start`, load frame B during compute, `start` again → frame B output immediately follows frame A after 12 compute cycles, with 16 total `vld_out` cycles.
- Saturation: load eight 255s → X[0]=(255,0) saturated and other bins (0,0). Load eight −256s → X[0]=(−256,0).
- Reset mid-OUTPUT after X[3] → `vld_out` drops next cycle and X[4..7] are never emitted.
